useq_multiplier: RTL and testbench

//   Sequential unsigned shift-add multiplier. It is the inverse of the UDivider step chain.

---
 rtl/useq_multiplier.sv | 107 ++++++++++
 tb/tb_useq_multiplier.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Optional macro USEQ_MUL_EARLY_TERM_EN finishes early once the remaining multiplier bits are zero.
module useq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH:0]        acc_q, acc_d;
    logic [WIDTH-1:0]      mq_q, mq_d;
    logic [CW-1:0]         count_q, count_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    logic [WIDTH-1:0]      addend;
    logic [WIDTH:0]        sum;
    logic [2*WIDTH-1:0]    step;
    logic [2*WIDTH-1:0]    final_val;
    logic                  finish;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        count_d   = count_q;
        product_d = product_q;

        addend = mq_q[0] ? mcand_q : '0;
        sum    = acc_q + {1'b0, addend};
        step   = {sum, mq_q[WIDTH-1:1]};

`ifdef USEQ_MUL_EARLY_TERM_EN
        // Unprocessed bits sit in mq_q[WIDTH-1-count:0]; bit 0 is consumed this cycle.
        finish    = ((mq_q & ({WIDTH{1'b1}} >> count_q)) >> 1) == '0;
        final_val = step >> (LAST - count_q);
`else
        finish    = (count_q == LAST);
        final_val = step;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    mcand_d = multiplicand;
                    mq_d    = multiplier;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                acc_d   = {1'b0, step[2*WIDTH-1:WIDTH]};
                mq_d    = step[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (finish) begin
                    state_d   = DONE;
                    product_d = final_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_useq_multiplier.sv
// Self-checking bench for useq_multiplier (WIDTH=32), scoreboard of expected products.
// Latency expectations follow USEQ_MUL_EARLY_TERM_EN when it is defined.
module tb_useq_multiplier;

    localparam int WIDTH = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    multiplicand = '0;
    logic [WIDTH-1:0]    multiplier = '0;
    logic [2*WIDTH-1:0]  product;
    logic                busy;
    logic                done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    useq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Edges from the accept edge (inclusive) until done is visible.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef USEQ_MUL_EARLY_TERM_EN
        int hi = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
        return hi + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    // Drive a one-cycle start; returns at the falling edge after the accept edge.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        exp_q.push_back({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 1;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        seen = done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
        end
        n_cmp++;
        if (product !== '0) begin
            n_bad++;
            $display("FAIL reset_product: got %h, required 0", product);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses = 0;
`ifdef USEQ_MUL_EARLY_TERM_EN
        launch(32'd7, 32'h8000_0009);
`else
        launch(32'd7, 32'd9);
`endif
        repeat (9) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy: got %b, required 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h, required 0 0 0", busy, done, product);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL midrun_no_done: got %0d pulses, required 0", pulses);
        end
    endtask

    task automatic test_basic;
        int lat;
        bit seen;
        logic [2*WIDTH-1:0] exp;
        launch(32'd6, 32'd7);
        wait_done(60, lat, seen);
        n_cmp++;
        if (!seen || lat !== exp_lat(32'd7)) begin
            n_bad++;
            $display("FAIL basic_latency: seen=%b cycles=%0d, required %0d", seen, lat, exp_lat(32'd7));
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (product !== exp || exp !== 64'd42) begin
            n_bad++;
            $display("FAIL basic_product: got %0d, required 42", product);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_at_done: got %b, required 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || product !== 64'd42) begin
            n_bad++;
            $display("FAIL basic_done_width: done=%b product=%0d, required 0 42", done, product);
        end
    endtask

    task automatic test_extremes;
        logic [WIDTH-1:0] ta[3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [WIDTH-1:0] tb[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [2*WIDTH-1:0] lit[3] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0000_8000_0000};
        for (int k = 0; k < 3; k++) begin
            int lat;
            bit seen;
            logic [2*WIDTH-1:0] exp;
            launch(ta[k], tb[k]);
            wait_done(60, lat, seen);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!seen || lat !== exp_lat(tb[k])) begin
                n_bad++;
                $display("FAIL extreme%0d_latency: seen=%b cycles=%0d, required %0d", k, seen, lat, exp_lat(tb[k]));
            end
            n_cmp++;
            if (product !== exp || exp !== lit[k]) begin
                n_bad++;
                $display("FAIL extreme%0d_product: got %h, required %h", k, product, lit[k]);
            end
        end
    endtask

    task automatic test_busy_start;
        int pulses = 0;
        bit overlap = 1'b0;
        logic [2*WIDTH-1:0] got = '0;
        logic [2*WIDTH-1:0] exp;
        launch(32'd3, 32'd5);
        for (int i = 1; i <= 45; i++) begin
            start        = (i <= 2);
            multiplicand = (i <= 2) ? 32'hFF : 32'd3;
            multiplier   = (i <= 2) ? 32'hFF : 32'd5;
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (done) begin
                pulses++;
                got = product;
            end
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp || exp !== 64'd15) begin
            n_bad++;
            $display("FAIL busy_start_product: got %0d, required 15", got);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL busy_start_pulses: got %0d, required 1", pulses);
        end
        n_cmp++;
        if (overlap !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_done_overlap: got 1, required 0");
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit seen;
        logic [2*WIDTH-1:0] first;
        logic [2*WIDTH-1:0] exp;
        launch(32'h1234, 32'h10);
        wait_done(60, lat, seen);
        first = exp_q.pop_front();
        n_cmp++;
        if (!seen || product !== first) begin
            n_bad++;
            $display("FAIL b2b_first: seen=%b product=%h, required %h", seen, product, first);
        end
        start        = 1'b1;
        multiplicand = 32'h1_0000;
        multiplier   = 32'h1_0000;
        exp_q.push_back(64'h1_0000_0000);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || product !== first) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b product=%h, required 1 %h", busy, product, first);
        end
        wait_done(60, lat, seen);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat !== exp_lat(32'h1_0000)) begin
            n_bad++;
            $display("FAIL b2b_latency: seen=%b cycles=%0d, required %0d", seen, lat, exp_lat(32'h1_0000));
        end
        n_cmp++;
        if (product !== exp) begin
            n_bad++;
            $display("FAIL b2b_product: got %h, required %h", product, exp);
        end
    endtask

    task automatic test_latency_profile;
        logic [WIDTH-1:0] bs[3] = '{32'h0, 32'h10, 32'h8000_0000};
`ifdef USEQ_MUL_EARLY_TERM_EN
        int lats[3] = '{2, 6, 33};
`else
        int lats[3] = '{33, 33, 33};
`endif
        for (int k = 0; k < 3; k++) begin
            int lat;
            bit seen;
            logic [2*WIDTH-1:0] exp;
            launch(32'hDEAD_BEEF, bs[k]);
            wait_done(60, lat, seen);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!seen || lat !== lats[k]) begin
                n_bad++;
                $display("FAIL profile%0d_latency: seen=%b cycles=%0d, required %0d", k, seen, lat, lats[k]);
            end
            n_cmp++;
            if (product !== exp) begin
                n_bad++;
                $display("FAIL profile%0d_product: got %h, required %h", k, product, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_extremes();
        test_busy_start();
        test_back_to_back();
        test_latency_profile();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
